serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Parametrised serial frame receiver: next generation of the single-bit-in / parallel-word-out transceiver path. It hunts a bit stream for a configurable sync word, then deserialises a fixed number of parity-protected words per frame. Each good word is also presented as a left-justified DAC code. It sits between the serial line input and the downstream sample consumer. It adds frame sync, parity checking, multi-word frames and an error counter.

## Interface

Parameters:
- DATA_W, 8, payload word width in bits (>= 2).
- OUT_W, 12, width of signal_out (must be >= DATA_W).
- SYNC_W, 8, sync pattern length in bits (>= 2).
- SYNC, 8'hA5, sync pattern, compared MSB-first.
- WORDS, 2, payload words per frame (>= 1).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk, input, 1, rising-edge clock.
- arst, input, 1, asynchronous reset, active-low.
- en, input, 1, bit-valid qualifier; data is sampled only on edges where en = 1.
- data, input, 1, serial bit.
- done, output, 1, one-cycle pulse per received word (good or bad).
- q, output, DATA_W, last received word (good or bad).
- parity_err, output, 1, parity result of the word flagged by the most recent done.
- signal_out, output, OUT_W, last good word, zero-filled on the LSB side.
- locked, output, 1, high while the FSM is in PAYLOAD or PARITY.
- err_cnt, output, 8, saturating count of parity errors.

## Operation

- Reset is asynchronous (arst = 0).
  - State goes to HUNT.
  - All counters and shift registers clear.
  - All outputs are 0.
- Reset is released synchronously in effect: the first sample is taken on the first rising edge with arst = 1 and en = 1.
- en = 0 freezes all state. No counter advances and no output changes, except that done drops.
- FSM states: HUNT, PAYLOAD, PARITY.
- HUNT:
  - Each sampled bit shifts into a SYNC_W-bit register, MSB-first.
  - A fill counter counts bits since entry into HUNT, saturating at SYNC_W.
  - Match condition: {reg[SYNC_W-2:0], data} == SYNC, and at least SYNC_W-1 bits are already held since entry.
  - On a match, go to PAYLOAD. The bit and word counters reset to 0.
  - The fill counter and shift register clear on every entry into HUNT, so stale payload bits can never contribute to a match.
- PAYLOAD:
  - DATA_W bits are shifted MSB-first into the word register.
  - After the DATA_W-th bit, go to PARITY.
- PARITY:
  - The sampled bit is the parity bit.
  - ok = (XOR of all word bits ^ parity bit) == PARITY_ODD.
  - On this edge:
    - q <= word.
    - parity_err <= !ok.
    - done <= 1.
  - If ok: signal_out <= word << (OUT_W - DATA_W).
  - If not ok: signal_out is held, and err_cnt increments, saturating at 255.
  - If the word counter equals WORDS-1, go to HUNT. Otherwise increment the word counter and return to PAYLOAD.
- Between done pulses, q, parity_err and signal_out hold their values.
- There is no resync inside a frame. A frame always consumes exactly WORDS × (DATA_W + 1) bits after the sync.

## Timing

- Latency: done, q, parity_err, signal_out and err_cnt update on the same clock edge that samples the parity bit. They are visible in the following cycle.
- done is high for exactly one cycle.
- The next sample edge after a sync match takes payload bit MSB. There are no idle bits.
- locked:
  - Rises on the edge that detects sync.
  - Falls on the edge that samples the parity bit of the last word.
- Back-to-back frames: sync bits may immediately follow the last parity bit. The earliest possible re-lock is SYNC_W sampled bits later.
- Reset mid-frame: the frame is discarded without a done pulse, and outputs return to 0.

## Test plan

Defaults for all tests: DATA_W=8, OUT_W=12, SYNC=8'hA5, WORDS=2, even parity, en=1.

1. Reset check: hold arst=0 with random data -> done=0, q=0, signal_out=0, locked=0, err_cnt=0, parity_err=0.
2. Clean frame:
   - Stimulus: bits A5, then 3C+p0, then 81+p0.
   - First word: done pulse, q=0x3C, signal_out=0x3C0.
   - Second word: done pulse, q=0x81, signal_out=0x810.
   - Response: locked falls with the second done, and err_cnt=0.
3. Parity error:
   - Stimulus: after frame 2, send A5, then 3C+p1, then 55+p0.
   - First word: q=0x3C, parity_err=1, signal_out stays 0x810, err_cnt=1.
   - Second word: q=0x55, parity_err=0, signal_out=0x550.
4. Sliding sync:
   - Stimulus: bits 1,0,1,0,1,0,0,1,0,1, i.e. 10 then A5.
   - Response: locked rises exactly on the 10th bit, with no earlier lock.
   - Follow with a frame and check it decodes correctly.
5. en gaps: repeat test 2 with en=0 for 5 cycles inside each word (data toggling) -> identical q and signal_out sequence, and exactly two done pulses.
6. Reset mid-payload:
   - Stimulus: assert arst=0 after 4 payload bits.
   - Response: all outputs 0, state is HUNT, and no done pulse occurs.
   - After release, a full clean frame decodes as in test 2.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, then deserialises WORDS
// parity-protected words per frame and presents good words as a DAC code.
module serial_frame_rx #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       OUT_W      = 12,
    parameter int unsigned       SYNC_W     = 8,
    parameter logic [SYNC_W-1:0] SYNC       = 8'hA5,
    parameter int unsigned       WORDS      = 2,
    parameter bit                PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              en,
    input  logic              data,
    output logic              done,
    output logic [DATA_W-1:0] q,
    output logic              parity_err,
    output logic [OUT_W-1:0]  signal_out,
    output logic              locked,
    output logic [7:0]        err_cnt
);

    localparam int unsigned FW = $clog2(SYNC_W + 1);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam int unsigned WW = $clog2(WORDS + 1);

    localparam logic [FW-1:0] FILL_MAX   = FW'(SYNC_W);
    localparam logic [FW-1:0] FILL_MATCH = FW'(SYNC_W - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
    localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS - 1);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        PARITY
    } state_t;

    state_t              state, next_state;
    logic [SYNC_W-1:0]   sync_sr;
    logic [SYNC_W-1:0]   sync_next;
    logic [FW-1:0]       fill;
    logic [BW-1:0]       bit_cnt;
    logic [WW-1:0]       word_cnt;
    logic [DATA_W-1:0]   word_sr;
    logic                match;
    logic                parity_ok;

    always_comb begin
        sync_next  = {sync_sr[SYNC_W-2:0], data};
        match      = (sync_next == SYNC) && (fill >= FILL_MATCH);
        parity_ok  = ((^word_sr) ^ data) == PARITY_ODD;
        next_state = state;
        if (en) begin
            case (state)
                HUNT:    if (match) next_state = PAYLOAD;
                PAYLOAD: if (bit_cnt == BIT_LAST) next_state = PARITY;
                PARITY:  next_state = (word_cnt == WORD_LAST) ? HUNT : PAYLOAD;
                default: next_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync_sr    <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            word_sr    <= '0;
            done       <= 1'b0;
            q          <= '0;
            parity_err <= 1'b0;
            signal_out <= '0;
            err_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        // Hunt history is cleared on leaving HUNT and untouched
                        // elsewhere, so every re-entry starts from an empty history.
                        if (match) begin
                            sync_sr  <= '0;
                            fill     <= '0;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end else begin
                            sync_sr <= sync_next;
                            if (fill != FILL_MAX) fill <= fill + 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        word_sr <= {word_sr[DATA_W-2:0], data};
                        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        done       <= 1'b1;
                        q          <= word_sr;
                        parity_err <= !parity_ok;
                        if (parity_ok) begin
                            signal_out <= OUT_W'(word_sr) << (OUT_W - DATA_W);
                        end else if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign locked = (state != HUNT);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed scenarios plus randomized frames,
// checked every sampled cycle against a bit-stream reference model.
module tb_serial_frame_rx;

    localparam int       DATA_W     = 8;
    localparam int       OUT_W      = 12;
    localparam int       SYNC_W     = 8;
    localparam int       WORDS      = 2;
    localparam logic [7:0] SYNC     = 8'hA5;
    localparam bit       PARITY_ODD = 1'b0;

    logic              clk  = 1'b0;
    logic              arst = 1'b0;
    logic              en   = 1'b0;
    logic              data = 1'b0;
    logic              done;
    logic [DATA_W-1:0] q;
    logic              parity_err;
    logic [OUT_W-1:0]  signal_out;
    logic              locked;
    logic [7:0]        err_cnt;

    serial_frame_rx #(
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W),
        .SYNC_W    (SYNC_W),
        .SYNC      (SYNC),
        .WORDS     (WORDS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .data      (data),
        .done      (done),
        .q         (q),
        .parity_err(parity_err),
        .signal_out(signal_out),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    // Reference model: history of bits since hunting began, collected payload bits.
    int m_hist, m_fill, m_locked, m_nbits, m_word, m_widx;
    int m_q, m_perr, m_sig, m_err, m_done;

    function automatic void model_reset();
        m_hist = 0; m_fill = 0; m_locked = 0; m_nbits = 0; m_word = 0; m_widx = 0;
        m_q = 0; m_perr = 0; m_sig = 0; m_err = 0; m_done = 0;
    endfunction

    function automatic void model_step(input logic b);
        int ok;
        m_done = 0;
        if (m_locked == 0) begin
            m_hist = ((m_hist << 1) | int'(b)) & 'hFF;
            m_fill++;
            if (m_fill >= SYNC_W && m_hist == int'(SYNC)) begin
                m_locked = 1; m_nbits = 0; m_word = 0; m_widx = 0;
            end
        end else if (m_nbits < DATA_W) begin
            m_word = (m_word << 1) | int'(b);
            m_nbits++;
        end else begin
            ok = ((($countones(m_word) + int'(b)) % 2) == int'(PARITY_ODD)) ? 1 : 0;
            m_done = 1;
            m_q    = m_word;
            m_perr = (ok != 0) ? 0 : 1;
            if (ok != 0) m_sig = (m_word << (OUT_W - DATA_W)) & 'hFFF;
            else if (m_err < 255) m_err++;
            m_nbits = 0; m_word = 0; m_widx++;
            if (m_widx == WORDS) begin
                m_locked = 0; m_hist = 0; m_fill = 0;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("done",       32'(done),       32'(m_done));
        check("q",          32'(q),          32'(m_q));
        check("parity_err", 32'(parity_err), 32'(m_perr));
        check("signal_out", 32'(signal_out), 32'(m_sig));
        check("locked",     32'(locked),     32'(m_locked));
        check("err_cnt",    32'(err_cnt),    32'(m_err));
    endtask

    task automatic send_bit(input logic b, input logic e);
        @(negedge clk);
        data = b;
        en   = e;
        @(posedge clk);
        if (e) model_step(b);
        else m_done = 0;
        #1;
        compare_all();
        if (done) n_done++;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b1);
    endtask

    // gap_at >= 0 inserts five en=0 cycles (data toggling) before that bit index
    task automatic send_word(input logic [7:0] w, input logic bad, input int gap_at, input bit rnd_gaps);
        logic [8:0] bits;
        bits = {w, (^w) ^ PARITY_ODD ^ bad};
        for (int i = 8; i >= 0; i--) begin
            if (gap_at == 8 - i) for (int g = 0; g < 5; g++) send_bit(g[0], 1'b0);
            if (rnd_gaps) while ($urandom_range(0, 3) == 0) send_bit(1'($urandom), 1'b0);
            send_bit(bits[i], 1'b1);
        end
    endtask

    task automatic reset_hold(input int n);
        @(negedge clk);
        arst = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data = 1'($urandom);
            en   = 1'($urandom);
            #1;
            compare_all();
        end
        @(negedge clk);
        en   = 1'b0;
        arst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] slide;
        model_reset();

        // 1: reset with random data
        reset_hold(5);

        // 2: clean frame
        send_byte(SYNC);
        check("t2_locked_in", 32'(locked), 32'd1);
        send_word(8'h3C, 1'b0, -1, 1'b0);
        check("t2_q0", 32'(q), 32'h3C);
        check("t2_sig0", 32'(signal_out), 32'h3C0);
        send_word(8'h81, 1'b0, -1, 1'b0);
        check("t2_q1", 32'(q), 32'h81);
        check("t2_sig1", 32'(signal_out), 32'h810);
        check("t2_done1", 32'(done), 32'd1);
        check("t2_unlock", 32'(locked), 32'd0);
        check("t2_err", 32'(err_cnt), 32'd0);

        // 3: parity error then good word
        send_byte(SYNC);
        send_word(8'h3C, 1'b1, -1, 1'b0);
        check("t3_q0", 32'(q), 32'h3C);
        check("t3_perr0", 32'(parity_err), 32'd1);
        check("t3_sig0", 32'(signal_out), 32'h810);
        check("t3_err", 32'(err_cnt), 32'd1);
        send_word(8'h55, 1'b0, -1, 1'b0);
        check("t3_q1", 32'(q), 32'h55);
        check("t3_perr1", 32'(parity_err), 32'd0);
        check("t3_sig1", 32'(signal_out), 32'h550);

        // 4: sliding sync, lock exactly on the 10th bit
        slide = 10'b1010100101;
        for (int i = 9; i >= 0; i--) begin
            send_bit(slide[i], 1'b1);
            check("t4_lock", 32'(locked), (i == 0) ? 32'd1 : 32'd0);
        end
        send_word(8'h12, 1'b0, -1, 1'b0);
        send_word(8'h34, 1'b0, -1, 1'b0);
        check("t4_q", 32'(q), 32'h34);
        check("t4_sig", 32'(signal_out), 32'h340);

        // 5: en gaps inside each word
        n_done = 0;
        send_byte(SYNC);
        send_word(8'h3C, 1'b0, 3, 1'b0);
        check("t5_sig0", 32'(signal_out), 32'h3C0);
        send_word(8'h81, 1'b0, 5, 1'b0);
        check("t5_q1", 32'(q), 32'h81);
        check("t5_sig1", 32'(signal_out), 32'h810);
        check("t5_ndone", 32'(n_done), 32'd2);

        // 6: asynchronous reset after 4 payload bits
        send_byte(SYNC);
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h3C >> i), 1'b1);
        @(negedge clk);
        #2 arst = 1'b0;
        #1;
        check("t6_q", 32'(q), 32'd0);
        check("t6_sig", 32'(signal_out), 32'd0);
        check("t6_lock", 32'(locked), 32'd0);
        check("t6_err", 32'(err_cnt), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        reset_hold(3);
        n_done = 0;
        send_byte(SYNC);
        send_word(8'h3C, 1'b0, -1, 1'b0);
        send_word(8'h81, 1'b0, -1, 1'b0);
        check("t6_q1", 32'(q), 32'h81);
        check("t6_sig1", 32'(signal_out), 32'h810);
        check("t6_ndone", 32'(n_done), 32'd2);

        // Randomized frames: leading garbage, random en gaps, random parity faults
        for (int f = 0; f < 30; f++) begin
            int ng;
            ng = int'($urandom_range(0, 12));
            for (int g = 0; g < ng; g++) send_bit(1'($urandom), 1'($urandom));
            send_byte(SYNC);
            for (int w = 0; w < WORDS; w++)
                send_word(8'($urandom), 1'($urandom_range(0, 3) == 0), -1, 1'b1);
        end

        // Error counter saturation
        for (int f = 0; f < 130; f++) begin
            send_byte(SYNC);
            send_word(8'($urandom), 1'b1, -1, 1'b0);
            send_word(8'($urandom), 1'b1, -1, 1'b0);
        end
        check("sat_err", 32'(err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
